// File: rtl/temporizador_regressivo.sv
// temporizador_regressivo: loadable N-bit down-counter timer with a small
// control FSM. A value is loaded with carrega, started with inicia and
// decremented once per qualified tick (conta). A one-cycle fim pulse marks
// expiry. pausa freezes the count without losing it.
module temporizador_regressivo #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic         inicia,
  input  logic         pausa,
  input  logic         conta,
  output logic [N-1:0] Q,
  output logic         zero,
  output logic         ocupado,
  output logic         fim,
  output logic [1:0]   db_estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    FIM      = 2'b11
  } estado_t;

  estado_t      r_estado;
  logic [N-1:0] r_q;

  // Count of one means the next tick lands on zero and expires the timer.
  logic w_ultimo;
  assign w_ultimo = (r_q <= N'(1));

  // State and count update: reset > carrega > FSM. The count only moves
  // down from a non-zero value inside CONTANDO, so it can never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_q      <= '0;
    end else if (carrega) begin
      // Load aborts any count in progress; no expiry pulse is produced.
      r_q      <= D;
      r_estado <= OCIOSO;
    end else begin
      case (r_estado)
        OCIOSO: begin
          // Starting from zero expires at once instead of counting.
          if (inicia)
            r_estado <= (r_q != '0) ? CONTANDO : FIM;
        end
        CONTANDO: begin
          if (pausa) begin
            r_estado <= PAUSADO;
          end else if (conta) begin
            if (w_ultimo) begin
              r_q      <= '0;
              r_estado <= FIM;
            end else begin
              r_q <= r_q - N'(1);
            end
          end
        end
        PAUSADO: begin
          // Resuming spends the release cycle; the tick there is dropped.
          if (!pausa)
            r_estado <= CONTANDO;
        end
        FIM: begin
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  // Outputs are decoded from the state register only, so they are Moore.
  assign Q         = r_q;
  assign zero      = (r_q == '0);
  assign ocupado   = (r_estado == CONTANDO) || (r_estado == PAUSADO);
  assign fim       = (r_estado == FIM);
  assign db_estado = r_estado;

endmodule

// File: doc/temporizador_regressivo.md
Name: temporizador_regressivo

Overview:
- Loadable N-bit down-counter timer with a small control FSM. It is the count-down complement to the team's 74163-style up counter.
- A value is loaded, counting is started, and the count decrements once per qualified tick (`conta`). A one-cycle `fim` pulse is issued when the count reaches zero.
- Used by datapaths/UCs that need timeouts (e.g. response-time limits) driven from a prescaled tick.

Parameters:
- N, 8, width of the count register and load value.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- carrega  input  1  synchronous load: Q <= D; highest priority after reset.
- D  input  N  load value.
- inicia  input  1  start request, sampled in OCIOSO.
- pausa  input  1  hold request; freezes Q while high.
- conta  input  1  tick enable; one decrement per cycle with conta=1 in CONTANDO.
- Q  output  N  current count (registered).
- zero  output  1  combinational, 1 when Q == 0.
- ocupado  output  1  1 in CONTANDO or PAUSADO.
- fim  output  1  one-cycle expiry pulse (Moore output of state FIM).
- db_estado  output  2  state code: OCIOSO=00, CONTANDO=01, PAUSADO=10, FIM=11.

Behaviour:
- Reset (async, any time, including mid-count):
  - Q=0, state=OCIOSO, fim=0, ocupado=0, db_estado=00.
  - zero=1, since it follows Q.
- Priority each edge: reset > carrega > state logic.
- carrega=1 in any state:
  - Q<=D; next state OCIOSO. An in-progress count is aborted with no fim pulse.
  - If FIM was current, fim drops next cycle.
- OCIOSO:
  - Q holds.
  - inicia=1 and Q!=0 -> CONTANDO. No decrement on the transition edge.
  - inicia=1 and Q==0 -> FIM (immediate expiry).
  - Otherwise stay.
- CONTANDO:
  - pausa=1 -> PAUSADO; Q holds. pausa wins over conta in the same cycle.
  - pausa=0, conta=1, Q>1 -> Q<=Q-1; stay.
  - pausa=0, conta=1, Q==1 -> Q<=0; next state FIM.
  - pausa=0, conta=0 -> hold.
  - inicia is ignored in this state.
- PAUSADO:
  - Q holds.
  - pausa=0 -> CONTANDO. The conta value in this cycle is ignored (no decrement).
- FIM:
  - fim=1 for exactly this one cycle; Q=0.
  - Unconditionally -> OCIOSO next edge, unless carrega (then load + OCIOSO).
  - inicia is ignored in FIM.
- Arithmetic:
  - Unsigned, width N.
  - Q never wraps below 0: decrement only occurs from Q>=1 in CONTANDO.
- Latency:
  - Load value L>0 with conta held 1: inicia edge k -> CONTANDO at k+1.
  - Q reaches 0 after L further edges; fim=1 during cycle k+1+L.
- ocupado and fim are decoded from the state register only (glitch-free, Moore).
- Unused state encodings are not reachable; if forced, they recover to OCIOSO next edge.

Test Plan:
- Reset mid-count:
  - Load 8'd20, start, 5 ticks (Q=15).
  - Assert reset asynchronously between edges -> Q=0, db_estado=00, ocupado=0 immediately, without waiting for an edge.
- Basic countdown:
  - carrega D=8'd3, inicia, conta=1 constant.
  - -> Q sequence 3,3,2,1,0; fim=1 exactly one cycle (when Q=0); then db_estado=00, fim=0.
- Tick gating and pause:
  - Load 8'd5, start, conta every 4th cycle.
  - -> Q decrements only on conta cycles.
  - pausa=1 with conta=1 at Q=3 -> Q stays 3, db_estado=10.
  - Release pausa -> resumes; fim after 3 more ticks.
- Zero start:
  - carrega D=0, inicia -> next cycle db_estado=11, fim=1; following cycle OCIOSO, Q=0.
- Load during count:
  - Load 8'd10, start, 4 ticks (Q=6).
  - carrega D=8'd2 together with conta=1 -> Q=2, OCIOSO, no fim pulse.
  - Restart -> fim after 2 ticks.
- Wide boundary (N=8):
  - Load 8'hFF, run with conta=1 -> 255 decrements then one fim pulse.
  - Q never shows 8'hFF again after leaving it (no wrap).
